// File: rtl/regfile_wr_ctrl_if.sv
// Write-port bundle between the writeback requesters, the write controller and the
// register file. master = requester/register-file side, slave = the controller.
interface regfile_wr_ctrl_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_a3;
    logic [DATA_W-1:0] rf_wd3;
    logic              init_done;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_a3, rf_wd3, init_done
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_a3, rf_wd3, init_done
    );
endinterface

// File: rtl/regfile_wr_ctrl.sv
// Register-file write-port owner: zero-fills x1..x(NUM_REGS-1) after reset, then
// round-robin arbitrates two writeback requesters onto the single registered write port.
module regfile_wr_ctrl #(
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_REGS       = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic              clk,
    input logic              rst,
    regfile_wr_ctrl_if.slave bus
);

    localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              last_grant_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_a3_q;
    logic [DATA_W-1:0] rf_wd3_q;
    logic              init_done_q;

    logic              grant0;
    logic              grant1;

    // Grant is combinational so a lone requester is accepted in the cycle it asks.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_q == StRun) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant_q;
                grant1 = !last_grant_q;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR_ON_RESET ? StInit : StRun;
            cnt_q        <= ADDR_W'(1);
            last_grant_q <= 1'b1;
            rf_we_q      <= 1'b0;
            rf_a3_q      <= '0;
            rf_wd3_q     <= '0;
            init_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    rf_we_q  <= 1'b1;
                    rf_a3_q  <= cnt_q;
                    rf_wd3_q <= '0;
                    // Leave before incrementing so cnt never wraps.
                    if (cnt_q == LastReg) begin
                        state_q     <= StRun;
                        init_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
                StRun: begin
                    init_done_q <= 1'b1;
                    if (grant0) begin
                        rf_we_q      <= (bus.req0_addr != '0);
                        rf_a3_q      <= bus.req0_addr;
                        rf_wd3_q     <= bus.req0_data;
                        last_grant_q <= 1'b0;
                    end else if (grant1) begin
                        rf_we_q      <= (bus.req1_addr != '0);
                        rf_a3_q      <= bus.req1_addr;
                        rf_wd3_q     <= bus.req1_data;
                        last_grant_q <= 1'b1;
                    end else begin
                        rf_we_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_a3      = rf_a3_q;
    assign bus.rf_wd3     = rf_wd3_q;
    assign bus.init_done  = init_done_q;

endmodule

// File: tb/tb_regfile_wr_ctrl.sv
// Directed bench for regfile_wr_ctrl: init walk, arbitration, x0 drop, reset mid-walk,
// and a second instance built without the init walk.
module tb_regfile_wr_ctrl;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;

    regfile_wr_ctrl_if #(.ADDR_W(5), .DATA_W(32)) ifa ();
    regfile_wr_ctrl_if #(.ADDR_W(5), .DATA_W(32)) ifb ();

    regfile_wr_ctrl #(
        .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .CLEAR_ON_RESET(1'b1)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    regfile_wr_ctrl #(
        .ADDR_W(5), .DATA_W(32), .NUM_REGS(32), .CLEAR_ON_RESET(1'b0)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic walk(input string tag);
        for (int i = 1; i <= 31; i++) begin
            tick();
            check({tag, " we"}, 32'(ifa.rf_we), 32'd1);
            check({tag, " a3"}, 32'(ifa.rf_a3), i);
            check({tag, " wd3"}, ifa.rf_wd3, 32'd0);
            check({tag, " init_done"}, 32'(ifa.init_done), 32'(i == 31));
            if (i < 31) begin
                check({tag, " ready0"}, 32'(ifa.req0_ready), 32'd0);
                check({tag, " ready1"}, 32'(ifa.req1_ready), 32'd0);
            end
        end
    endtask

    task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d);
        ifa.req0_valid = v;
        ifa.req0_addr  = a;
        ifa.req0_data  = d;
    endtask

    task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d);
        ifa.req1_valid = v;
        ifa.req1_addr  = a;
        ifa.req1_data  = d;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_a  = 1'b1;
        rst_b  = 1'b1;
        drive0(1'b0, 5'd0, 32'd0);
        drive1(1'b0, 5'd0, 32'd0);
        ifb.req0_valid = 1'b0;
        ifb.req0_addr  = '0;
        ifb.req0_data  = '0;
        ifb.req1_valid = 1'b0;
        ifb.req1_addr  = '0;
        ifb.req1_data  = '0;

        // Reset state; ready must stay low under reset even with a valid request.
        tick();
        tick();
        drive0(1'b1, 5'd2, 32'h1);
        #1;
        check("rst ready0", 32'(ifa.req0_ready), 32'd0);
        check("rst we", 32'(ifa.rf_we), 32'd0);
        check("rst a3", 32'(ifa.rf_a3), 32'd0);
        check("rst init_done", 32'(ifa.init_done), 32'd0);

        // Full init walk with both requesters pending.
        drive1(1'b1, 5'd3, 32'h2);
        rst_a = 1'b0;
        walk("walk1");
        drive0(1'b0, 5'd0, 32'd0);
        drive1(1'b0, 5'd0, 32'd0);
        tick();
        check("post walk we", 32'(ifa.rf_we), 32'd0);
        check("post walk a3 hold", 32'(ifa.rf_a3), 32'd31);
        check("post walk init_done", 32'(ifa.init_done), 32'd1);

        // Contention: req0 first after reset, then strict alternation.
        drive0(1'b1, 5'd3, 32'h11);
        drive1(1'b1, 5'd4, 32'h22);
        #1;
        check("arb1 ready0", 32'(ifa.req0_ready), 32'd1);
        check("arb1 ready1", 32'(ifa.req1_ready), 32'd0);
        tick();
        check("arb1 we", 32'(ifa.rf_we), 32'd1);
        check("arb1 a3", 32'(ifa.rf_a3), 32'd3);
        check("arb1 wd3", ifa.rf_wd3, 32'h11);
        drive0(1'b1, 5'd6, 32'h33);
        #1;
        check("arb2 ready0", 32'(ifa.req0_ready), 32'd0);
        check("arb2 ready1", 32'(ifa.req1_ready), 32'd1);
        tick();
        check("arb2 a3", 32'(ifa.rf_a3), 32'd4);
        check("arb2 wd3", ifa.rf_wd3, 32'h22);
        drive1(1'b0, 5'd0, 32'd0);
        #1;
        check("arb3 ready0", 32'(ifa.req0_ready), 32'd1);
        tick();
        check("arb3 a3", 32'(ifa.rf_a3), 32'd6);
        check("arb3 wd3", ifa.rf_wd3, 32'h33);
        drive0(1'b0, 5'd0, 32'd0);

        // Lone req0 write, one-cycle latency, then we falls and a3/wd3 hold.
        drive0(1'b1, 5'd5, 32'hDEADBEEF);
        #1;
        check("solo ready0", 32'(ifa.req0_ready), 32'd1);
        check("solo ready1", 32'(ifa.req1_ready), 32'd0);
        tick();
        check("solo we", 32'(ifa.rf_we), 32'd1);
        check("solo a3", 32'(ifa.rf_a3), 32'd5);
        check("solo wd3", ifa.rf_wd3, 32'hDEADBEEF);
        drive0(1'b0, 5'd0, 32'd0);
        tick();
        check("idle we", 32'(ifa.rf_we), 32'd0);
        check("idle a3 hold", 32'(ifa.rf_a3), 32'd5);
        check("idle wd3 hold", ifa.rf_wd3, 32'hDEADBEEF);

        // Write to x0: handshake completes but nothing is written; grant still recorded.
        drive1(1'b1, 5'd0, 32'hFFFFFFFF);
        #1;
        check("x0 ready1", 32'(ifa.req1_ready), 32'd1);
        tick();
        check("x0 we", 32'(ifa.rf_we), 32'd0);
        drive1(1'b1, 5'd10, 32'h66);
        drive0(1'b1, 5'd9, 32'h55);
        #1;
        check("x0 last_grant ready0", 32'(ifa.req0_ready), 32'd1);
        check("x0 last_grant ready1", 32'(ifa.req1_ready), 32'd0);
        tick();
        check("x0 follow a3", 32'(ifa.rf_a3), 32'd9);
        check("x0 follow wd3", ifa.rf_wd3, 32'h55);
        drive0(1'b0, 5'd0, 32'd0);
        drive1(1'b0, 5'd0, 32'd0);

        // Reset in the middle of the walk restarts it from x1.
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("part walk a3", 32'(ifa.rf_a3), i);
        end
        rst_a = 1'b1;
        tick();
        check("mid rst we", 32'(ifa.rf_we), 32'd0);
        check("mid rst init_done", 32'(ifa.init_done), 32'd0);
        rst_a = 1'b0;
        drive0(1'b1, 5'd7, 32'h77);
        walk("walk2");
        drive0(1'b0, 5'd0, 32'd0);

        // No init walk: RUN straight after reset, init_done one cycle after rst drops.
        tick();
        check("b rst init_done", 32'(ifb.init_done), 32'd0);
        check("b rst we", 32'(ifb.rf_we), 32'd0);
        rst_b = 1'b0;
        ifb.req0_valid = 1'b1;
        ifb.req0_addr  = 5'd12;
        ifb.req0_data  = 32'hCAFE;
        #1;
        check("b first ready0", 32'(ifb.req0_ready), 32'd1);
        tick();
        ifb.req0_valid = 1'b0;
        check("b init_done", 32'(ifb.init_done), 32'd1);
        check("b we", 32'(ifb.rf_we), 32'd1);
        check("b a3", 32'(ifb.rf_a3), 32'd12);
        check("b wd3", ifb.rf_wd3, 32'hCAFE);
        tick();
        check("b idle we", 32'(ifb.rf_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
